nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that time-shares one 4-bit ripple-carry adder slice to add WIDTH-bit operands.
//  It processes one nibble per clock, LSB first, and keeps the inter-nibble carry in a register.
//  Sits between an operand producer and a result consumer, with valid/ready on both sides.
//  Trades latency (WIDTH/4 cycles) for area versus a full-width adder.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4 and >= 4
//  NIBBLES  WIDTH/4 (localparam)   number of adder passes per operation
// PORTS
//  clk        input   1      rising-edge clock
//  rst_n      input   1      asynchronous active-low reset
//  in_valid   input   1      operand set valid
//  in_ready   output  1      controller can accept operands
//  a          input   WIDTH  operand A
//  b          input   WIDTH  operand B
//  cin        input   1      carry into nibble 0
//  out_valid  output  1      result valid
//  out_ready  input   1      consumer accepts result
//  sum        output  WIDTH  result
//  cout       output  1      carry out of the top nibble
//  busy       output  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, cnt=0, carry=0, sum=0, cout=0, out_valid=0.
//   In reset, in_ready=0; it rises on the first clk edge after release.
//  FSM has three states.
//   IDLE: in_ready=1. On in_valid&&in_ready, latch a, b into shift registers and carry<=cin,
//    set cnt<=0, then go to RUN.
//   RUN: in_ready=0. Each cycle the slice adds a_sh[3:0] + b_sh[3:0] + carry.
//    The 4-bit result shifts into sum from the top; the slice carry is written to carry.
//    a_sh and b_sh shift right by 4, and cnt is incremented.
//    When cnt==NIBBLES-1, go to DONE and set cout<=slice carry.
//   DONE: out_valid=1; sum and cout are held stable. On out_ready, go to IDLE and drop out_valid.
//  Latency: out_valid rises exactly NIBBLES clocks after the accept edge.
//  Throughput: one operation per NIBBLES+2 cycles minimum; operations never overlap.
//  in_valid outside IDLE is ignored (in_ready=0). Operands are sampled only at the accept edge.
//  out_ready low in DONE: hold indefinitely with no change to sum or cout.
//  Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
//  cnt is $clog2(NIBBLES)+1 bits wide and never wraps within an operation.
//  rst_n asserted mid-RUN or mid-DONE: abort immediately; all outputs take reset values
//   and the partial result is discarded.
//  sum is valid only while out_valid=1. Intermediate values during RUN are not guaranteed.
// CONFIGURATION
//  SUBTRACT_EN defined:
//   - adds input port op_sub (1 bit), sampled with the operands.
//   - When op_sub=1, each B nibble is inverted before the slice, and carry<=1 at accept
//     (cin is ignored), giving sum=a-b.
//   - cout=1 means no borrow.
//  SUBTRACT_EN undefined: no op_sub port; the block is add only.
// STRUCTURE
//  Shared package nibble_add_pkg:
//   - NIB_W=4
//   - state enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//  Sub-module nibble_adder4 (combinational):
//   - inputs x[3:0], y[3:0], ci; outputs s[3:0], co
//   - built from gate-level full adders; exactly one instance
//  The top level holds the FSM, counter, carry register and shift registers.
// TESTING (WIDTH=16 unless noted)
//  1. a=16'hFFFF, b=16'h0001, cin=0 -> out_valid 4 clocks after accept, sum=16'h0000, cout=1.
//  2. a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
//  3. Backpressure: keep out_ready=0 for 3 cycles in DONE -> sum and cout stable, in_ready=0,
//     a second in_valid is not accepted until one cycle after the out_ready handshake.
//  4. Reset mid-op: pulse rst_n low after 2 RUN cycles -> out_valid=0, sum=0, state IDLE.
//     Then a=16'h000F, b=16'h0001 -> sum=16'h0010.
//  5. WIDTH=4: a=4'b1010, b=4'b1111, cin=0 -> sum=4'b1001, cout=1, 1 clock latency.
//  6. SUBTRACT_EN, op_sub=1: a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0.
//     With a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
//  Bench compares every result against a behavioural a+b+cin model over 1000 random vectors.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller states.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder4.sv
// 4-bit ripple-carry adder slice built from gate-level full adders.
// Latency: combinational.
// Backpressure: not applicable.
module nibble_adder4
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] c;

  assign c[0] = ci;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    logic p;
    assign p      = x[i] ^ y[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (p & c[i]);
  end

  assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds WIDTH-bit operands one nibble per clock through a single shared 4-bit slice (SUBTRACT_EN adds op_sub for a-b).
// Latency: out_valid rises NIBBLES clocks after the accept edge; one operation per NIBBLES+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the output handshake.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = $clog2(NIBBLES) + 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [NIB_W-1:0] slice_y;
  logic [NIB_W-1:0] slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry_init;
  logic [NIB_W-1:0] y_mask;

`ifdef SUBTRACT_EN
  // Subtraction is a + ~b + 1: invert each B nibble and force the initial carry.
  logic sub_q;
  assign y_mask     = {NIB_W{sub_q}};
  assign carry_init = op_sub ? 1'b1 : cin;
`else
  assign y_mask     = '0;
  assign carry_init = cin;
`endif

  assign slice_y = b_sh[NIB_W-1:0] ^ y_mask;

  nibble_adder4 u_slice (
    .x  (a_sh[NIB_W-1:0]),
    .y  (slice_y),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // New nibble enters the result from the top so after NIBBLES passes it is LSB-aligned.
  always_comb begin
    sum_nxt = sum >> NIB_W;
    sum_nxt[WIDTH-1 -: NIB_W] = slice_s;
  end

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
`ifdef SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= carry_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
`ifdef SUBTRACT_EN
            sub_q    <= op_sub;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> NIB_W;
          b_sh  <= b_sh >> NIB_W;
          sum   <= sum_nxt;
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(NIBBLES - 1)) begin
            cout      <= slice_co;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16 and WIDTH=4 instances).
// Latency: not applicable.
// Backpressure: not applicable.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef SUBTRACT_EN
  logic        op_sub = 1'b0;
  logic        op_sub4 = 1'b0;
`endif

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [3:0]  sum4;
  logic        cout4;
  logic        busy4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUBTRACT_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef SUBTRACT_EN
    .op_sub    (op_sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .busy      (busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result of one operation as a (WIDTH+1)-bit number: {cout, sum}.
  function automatic logic [16:0] model(input logic [15:0] va, input logic [15:0] vb,
                                        input logic vc, input logic vs);
    if (vs) return {1'b0, va} + {1'b0, ~vb} + 17'd1;
    else    return {1'b0, va} + {1'b0, vb} + {16'd0, vc};
  endfunction

  // Full operation on the 16-bit instance: wait for ready, accept, measure latency,
  // compare the result, hold it for 'hold' cycles under backpressure, then release.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs, input int hold);
    logic [16:0] exp;
    int          w;
    int          lat;
    exp = model(va, vb, vc, vs);
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    cin = vc;
`ifdef SUBTRACT_EN
    op_sub = vs;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'(~va);
    b = 16'(~vb);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(exp[15:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[16]));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(sum), 32'(exp[15:0]));
      check({tag, "_hold_cout"}, 32'(cout), 32'(exp[16]));
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [16:0] exp;
    int          lat;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Directed vectors
    run_op("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("t2", 16'h1234, 16'h4321, 1'b1, 1'b0, 1);

    // Backpressure: hold DONE 3 cycles with a competing in_valid asserted
    run_op("t3pre", 16'hABCD, 16'h1111, 1'b0, 1'b0, 0);
    a = 16'h8000; b = 16'h8000; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("t3_latency", 32'(lat), 32'd4);
    a = 16'h0101; b = 16'h0202; cin = 1'b0;
    in_valid = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      check("t3_sum", 32'(sum), 32'h0001);
      check("t3_cout", 32'(cout), 32'd1);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_hs_busy", 32'(busy), 32'd0);
    check("t3_hs_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t3_acc_busy", 32'(busy), 32'd1);
    check("t3_acc_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("t3b_latency", 32'(lat), 32'd4);
    check("t3b_sum", 32'(sum), 32'h0303);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-operation
    a = 16'h7777; b = 16'h7777; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_sum", 32'(sum), 32'd0);
    check("t4_cout", 32'(cout), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_idle_ready", 32'(in_ready), 32'd1);
    run_op("t4post", 16'h000F, 16'h0001, 1'b0, 1'b0, 0);

    // WIDTH=4 instance: single-cycle latency
    a4 = 4'b1010; b4 = 4'b1111; cin4 = 1'b0;
    in_valid4 = 1'b1;
    check("t5_in_ready", 32'(in_ready4), 32'd1);
    tick();
    in_valid4 = 1'b0;
    check("t5_early", 32'(out_valid4), 32'd0);
    tick();
    check("t5_out_valid", 32'(out_valid4), 32'd1);
    check("t5_sum", 32'(sum4), 32'h9);
    check("t5_cout", 32'(cout4), 32'd1);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("t5_drop", 32'(out_valid4), 32'd0);

`ifdef SUBTRACT_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op("t6b", 16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

    // Random vectors against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef SUBTRACT_EN
      rs = 1'($urandom);
`endif
      if (i == 0) begin
        exp = model(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        check("model_sanity", 32'(exp), 32'h1FFFF);
      end
      run_op("rnd", ra, rb, rc, rs, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
